// File: rtl/dbus_arbiter_pkg.sv
// Shared data-bus types and the arbiter state encoding used by dbus_arbiter
// and its testbench.
package dbus_arbiter_pkg;

  typedef enum logic [1:0] {
    MSIZE1 = 2'd0,
    MSIZE2 = 2'd1,
    MSIZE4 = 2'd2
  } msize_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    msize_t      size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dbus_arbiter.sv
// Two-requester data-bus arbiter: one outstanding transaction, registered
// downstream request, per-owner kill. Define DBUS_ARB_FIXED_PRIO_EN for fixed m0 priority.
module dbus_arbiter
  import dbus_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  m0_req,
  output dbus_resp_t m0_resp,
  input  dbus_req_t  m1_req,
  output dbus_resp_t m1_resp,
  input  logic       kill0,
  input  logic       kill1,
  output dbus_req_t  s_req,
  input  dbus_resp_t s_resp,
  output logic       busy,
  output arb_state_t dbg_state
);

  // Handshake: a requester holds valid until it sees addr_ok (or is killed);
  // s_req.valid is high only in ADDR and drops after the addr_ok cycle;
  // data_ok closes the transaction and returns the arbiter to IDLE.

  arb_state_t state, state_nx;
  logic       owner, owner_nx;
  logic       last, last_nx;
  logic       killed, killed_nx;
  dbus_req_t  req_q, req_q_nx;
  dbus_resp_t up_resp;

  logic elig0, elig1, grant_any, grant_idx;
  logic kill_owner, suppress;

  always_comb begin
    elig0     = m0_req.valid & ~kill0;
    elig1     = m1_req.valid & ~kill1;
    grant_any = elig0 | elig1;
`ifdef DBUS_ARB_FIXED_PRIO_EN
    grant_idx = ~elig0;
`else
    grant_idx = (elig0 & elig1) ? ~last : elig1;
`endif
  end

  // A kill arriving in the same cycle as the response already suppresses it.
  assign kill_owner = owner ? kill1 : kill0;
  assign suppress   = killed | kill_owner;

  always_comb begin
    state_nx  = state;
    owner_nx  = owner;
    last_nx   = last;
    killed_nx = killed;
    req_q_nx  = req_q;
    up_resp   = '0;
    unique case (state)
      IDLE: begin
        if (grant_any) begin
          req_q_nx       = grant_idx ? m1_req : m0_req;
          req_q_nx.valid = 1'b1;
          owner_nx       = grant_idx;
          killed_nx      = 1'b0;
          state_nx       = ADDR;
        end
      end
      ADDR: begin
        killed_nx = suppress;
        if (s_resp.addr_ok) begin
          up_resp.addr_ok = ~suppress;
          if (s_resp.data_ok) begin
            up_resp.data_ok = ~suppress;
            up_resp.data    = suppress ? '0 : s_resp.data;
            last_nx         = owner;
            state_nx        = IDLE;
          end else begin
            state_nx = DATA;
          end
        end
      end
      DATA: begin
        killed_nx = suppress;
        if (s_resp.data_ok) begin
          up_resp.data_ok = ~suppress;
          up_resp.data    = suppress ? '0 : s_resp.data;
          last_nx         = owner;
          state_nx        = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      owner  <= 1'b0;
      last   <= 1'b1;
      killed <= 1'b0;
      req_q  <= '0;
    end else begin
      state  <= state_nx;
      owner  <= owner_nx;
      last   <= last_nx;
      killed <= killed_nx;
      req_q  <= req_q_nx;
    end
  end

  always_comb begin
    s_req = '0;
    if (state == ADDR) begin
      s_req       = req_q;
      s_req.valid = 1'b1;
    end
  end

  assign m0_resp   = owner ? '0 : up_resp;
  assign m1_resp   = owner ? up_resp : '0;
  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Testbench for dbus_arbiter: reset and grant vector table, directed corner
// sequences, and random rounds against a transaction-level model.
module tb_dbus_arbiter;
  import dbus_arbiter_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  dbus_req_t  m0_req, m1_req, s_req;
  dbus_resp_t m0_resp, m1_resp, s_resp;
  logic       kill0, kill1, busy;
  arb_state_t dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic rr_last;  // index of the requester served most recently

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dbus_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_resp(m0_resp),
    .m1_req(m1_req), .m1_resp(m1_resp),
    .kill0(kill0), .kill1(kill1),
    .s_req(s_req), .s_resp(s_resp),
    .busy(busy), .dbg_state(dbg_state)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic dbus_req_t mk(input logic [31:0] a, input msize_t sz,
                                   input logic [3:0] st, input logic [31:0] d);
    dbus_req_t r;
    r.valid = 1'b1; r.addr = a; r.size = sz; r.strobe = st; r.data = d;
    return r;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; m0_req = '0; m1_req = '0; kill0 = 1'b0; kill1 = 1'b0; s_resp = '0;
    @(negedge clk);
    reset = 1'b0;
    rr_last = 1'b1;
  endtask

  // One round: the chosen requesters assert together, the bench plays the
  // slave, and every cycle checks downstream request and upstream responses.
  task automatic run_round(input logic use0, input logic use1,
                           input dbus_req_t r0, input dbus_req_t r1,
                           input int lat_a, input int lat_d,
                           input bit fix_data, input logic [31:0] fdata);
    int ord[$];
    int phase, cnt, dcnt, budget, last_done, first;
    logic drop0, drop1;
    dbus_req_t exp_cur;
    dbus_resp_t exp_up;
    @(negedge clk);
    m0_req = r0; m0_req.valid = use0;
    m1_req = r1; m1_req.valid = use1;
    if (use0 && use1) begin
`ifdef DBUS_ARB_FIXED_PRIO_EN
      first = 0;
`else
      first = rr_last ? 0 : 1;
`endif
      ord.push_back(first);
      ord.push_back(1 - first);
    end else if (use0) ord.push_back(0);
    else if (use1) ord.push_back(1);
    phase = 0; cnt = 0; dcnt = 0; budget = 0; last_done = -1;
    drop0 = 1'b0; drop1 = 1'b0; exp_cur = '0;
    while (ord.size() != 0 && budget < 80) begin
      @(negedge clk);
      budget++;
      if (drop0) begin m0_req.valid = 1'b0; drop0 = 1'b0; end
      if (drop1) begin m1_req.valid = 1'b0; drop1 = 1'b0; end
      s_resp = '0;
      if (phase == 0 && s_req.valid) begin
        exp_cur = (ord[0] == 0) ? r0 : r1;
        exp_cur.valid = 1'b1;
        chk("grant_req", 128'(s_req), 128'(exp_cur));
        if (last_done >= 0) chk("grant_gap", 128'(cyc - last_done), 128'(2));
        cnt  = (lat_a < 0) ? $urandom_range(0, 2) : lat_a;
        dcnt = (lat_d < 0) ? $urandom_range(0, 2) : lat_d;
        phase = 1;
      end
      if (phase == 1) begin
        chk("s_req_stable", 128'(s_req), 128'(exp_cur));
        if (cnt == 0) begin
          s_resp.addr_ok = 1'b1;
          if (dcnt == 0) begin
            s_resp.data_ok = 1'b1;
            s_resp.data = fix_data ? fdata : $urandom();
          end else phase = 2;
        end else cnt--;
      end else if (phase == 2) begin
        chk("s_req_low_in_data", 128'(s_req.valid), 128'(0));
        dcnt--;
        if (dcnt == 0) begin
          s_resp.data_ok = 1'b1;
          s_resp.data = fix_data ? fdata : $urandom();
        end
      end
      #1;
      exp_up = '0;
      exp_up.addr_ok = s_resp.addr_ok;
      exp_up.data_ok = s_resp.data_ok;
      exp_up.data    = s_resp.data_ok ? s_resp.data : 32'h0;
      chk("m0_resp", 128'(m0_resp), (phase != 0 && ord[0] == 0) ? 128'(exp_up) : 128'(0));
      chk("m1_resp", 128'(m1_resp), (phase != 0 && ord[0] == 1) ? 128'(exp_up) : 128'(0));
      chk("busy", 128'(busy), 128'(phase != 0));
      if (s_resp.addr_ok) begin
        if (ord[0] == 0) drop0 = 1'b1; else drop1 = 1'b1;
      end
      if (s_resp.data_ok) begin
        rr_last = ord[0][0];
        last_done = cyc;
        void'(ord.pop_front());
        phase = 0;
      end
    end
    if (ord.size() != 0) begin
      total++; bad++;
      $display("FAIL round_timeout actual=%0d pending required=0", ord.size());
    end
    @(negedge clk);
    s_resp = '0; m0_req.valid = 1'b0; m1_req.valid = 1'b0;
  endtask

  typedef struct {
    logic v0, k0, v1, k1;
    logic exp_v;
    logic exp_sel;
  } vec_t;

  vec_t tbl[8];

  initial begin
    dbus_req_t ra, rb;
    logic u0, u1;
    reset = 1'b1; m0_req = '0; m1_req = '0; kill0 = 1'b0; kill1 = 1'b0; s_resp = '0;
    rr_last = 1'b1;

    // First grant out of reset, including kill-in-IDLE rows
    tbl[0] = '{1, 0, 0, 0, 1, 0};
    tbl[1] = '{0, 0, 1, 0, 1, 1};
    tbl[2] = '{1, 0, 1, 0, 1, 0};
    tbl[3] = '{1, 1, 1, 0, 1, 1};
    tbl[4] = '{1, 1, 0, 0, 0, 0};
    tbl[5] = '{0, 0, 1, 1, 0, 0};
    tbl[6] = '{1, 0, 1, 1, 1, 0};
    tbl[7] = '{0, 0, 0, 0, 0, 0};

    do_reset();
    #1;
    chk("rst_state", 128'(dbg_state), 128'(IDLE));
    chk("rst_s_req", 128'(s_req), 128'(0));
    chk("rst_m0_resp", 128'(m0_resp), 128'(0));
    chk("rst_m1_resp", 128'(m1_resp), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));

    for (int i = 0; i < 8; i++) begin
      do_reset();
      m0_req = mk(32'h0000_1000, MSIZE4, 4'hf, 32'h0); m0_req.valid = tbl[i].v0;
      m1_req = mk(32'h0000_2000, MSIZE4, 4'hf, 32'h0); m1_req.valid = tbl[i].v1;
      kill0 = tbl[i].k0; kill1 = tbl[i].k1;
      @(negedge clk);
      chk("tbl_valid", 128'(s_req.valid), 128'(tbl[i].exp_v));
      chk("tbl_busy", 128'(busy), 128'(tbl[i].exp_v));
      if (tbl[i].exp_v) chk("tbl_addr", 128'(s_req.addr), tbl[i].exp_sel ? 128'(32'h2000) : 128'(32'h1000));
    end

    // Single read: addr_ok two cycles after request, data_ok one later
    do_reset();
    run_round(1, 0, mk(32'h8000_0010, MSIZE4, 4'h0, 32'h0), '0, 1, 1, 1'b1, 32'hDEAD_BEEF);

    // Simultaneous requests after reset, then again
    do_reset();
    ra = mk(32'h100, MSIZE4, 4'h0, 32'h0);
    rb = mk(32'h200, MSIZE4, 4'h0, 32'h0);
    run_round(1, 1, ra, rb, -1, -1, 1'b0, 32'h0);
    run_round(1, 1, ra, rb, -1, -1, 1'b0, 32'h0);

    // Store from m0 while m1 waits, with slow addr_ok
    ra = mk(32'h0000_0040, MSIZE4, 4'b1100, 32'h1234_0000);
    run_round(1, 1, ra, rb, 2, 1, 1'b0, 32'h0);

    // Kill in DATA for an m1 load
    do_reset();
    m1_req = mk(32'h300, MSIZE4, 4'h0, 32'h0);
    @(negedge clk);
    chk("kd_addr", 128'(s_req.addr), 128'(32'h300));
    s_resp.addr_ok = 1'b1;
    #1;
    chk("kd_addr_ok", 128'(m1_resp.addr_ok), 128'(1));
    @(negedge clk);
    s_resp = '0; m1_req.valid = 1'b0; kill1 = 1'b1;
    #1;
    chk("kd_state", 128'(dbg_state), 128'(DATA));
    @(negedge clk);
    kill1 = 1'b0; s_resp.data_ok = 1'b1; s_resp.data = 32'hCAFE_F00D;
    #1;
    chk("kd_m1_resp", 128'(m1_resp), 128'(0));
    chk("kd_m0_resp", 128'(m0_resp), 128'(0));
    @(negedge clk);
    s_resp = '0;
    #1;
    chk("kd_idle", 128'(dbg_state), 128'(IDLE));
    chk("kd_busy", 128'(busy), 128'(0));
    rr_last = 1'b1;
    run_round(0, 1, '0, mk(32'h304, MSIZE4, 4'h0, 32'h0), -1, -1, 1'b0, 32'h0);
    run_round(1, 1, mk(32'h500, MSIZE2, 4'h0, 32'h0), mk(32'h504, MSIZE1, 4'h0, 32'h0), -1, -1, 1'b0, 32'h0);

    // Reset while the slave withholds addr_ok
    do_reset();
    m0_req = mk(32'h400, MSIZE4, 4'h0, 32'h0);
    @(negedge clk);
    chk("ra_busy_before", 128'(busy), 128'(1));
    reset = 1'b1; m0_req = '0;
    @(negedge clk);
    reset = 1'b0;
    rr_last = 1'b1;
    #1;
    chk("ra_state", 128'(dbg_state), 128'(IDLE));
    chk("ra_s_req", 128'(s_req), 128'(0));
    chk("ra_busy", 128'(busy), 128'(0));
    chk("ra_m0_resp", 128'(m0_resp), 128'(0));
    chk("ra_m1_resp", 128'(m1_resp), 128'(0));

    // Random rounds
    for (int n = 0; n < 40; n++) begin
      ra = mk($urandom() & 32'hFFFF_FFFB, msize_t'($urandom_range(0, 2)),
              4'($urandom_range(0, 15)), $urandom());
      rb = mk($urandom() | 32'h0000_0004, msize_t'($urandom_range(0, 2)),
              4'($urandom_range(0, 15)), $urandom());
      u0 = 1'($urandom_range(0, 1));
      u1 = u0 ? 1'($urandom_range(0, 1)) : 1'b1;
      run_round(u0, u1, ra, rb, -1, -1, 1'b0, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dbus_arbiter.md
Name: dbus_arbiter

Overview:
- Shares the single data-bus port between two memory requesters: m0 is the older pipe's MMU, m1 is the younger pipe's MMU.
- Grants one request at a time and registers it onto the downstream dbus, then routes addr_ok/data_ok/data back to the owner only.
- Supports per-requester kill, driven by the CP0 flush, which suppresses the response to a killed owner.
- Sits between the MEM-stage MMUs and the dcache/uncached bridge; one outstanding transaction at a time.

Parameters:
- none; request and response shapes come from dbus_req_t / dbus_resp_t.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- m0_req  in  dbus_req_t  requester 0 request; valid is held until m0_resp.addr_ok or kill0.
- m0_resp  out  dbus_resp_t  response to requester 0.
- m1_req  in  dbus_req_t  requester 1 request; same rules as m0.
- m1_resp  out  dbus_resp_t  response to requester 1.
- kill0  in  1  flush for requester 0.
- kill1  in  1  flush for requester 1.
- s_req  out  dbus_req_t  downstream request.
- s_resp  in  dbus_resp_t  downstream response.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-high.
- Reset values: state=IDLE, owner=0, last=1 (m0 wins the first tie), killed=0, req_q='0. All outputs read '0: s_req, m0_resp, m1_resp, busy.
- Reset mid-transaction returns to IDLE with s_req.valid=0. The downstream is reset in the same cycle.
- States: IDLE, ADDR, DATA.
- IDLE, requester eligibility: mN is eligible if mN_req.valid && !killN.
  - If both are eligible, grant the one != last (round-robin).
  - Latch the granted request into req_q, set owner, clear killed, go to ADDR.
  - No response of any kind is given in IDLE.
- ADDR:
  - s_req = req_q with valid=1. The output is registered, so a request seen at cycle t appears on s_req.valid at t+1.
  - On s_resp.addr_ok, pulse addr_ok on the owner's response for 1 cycle, unless killed.
  - Next state: DATA. If s_resp.data_ok also arrives in the same cycle, the transaction completes directly (see DATA).
- DATA:
  - s_req.valid=0.
  - On s_resp.data_ok: owner_resp.data_ok=1 and owner_resp.data=s_resp.data for 1 cycle, unless killed. Then last=owner and go to IDLE.
- Kill:
  - killed is sticky. It is set when kill[owner] is high in ADDR or DATA, including the cycle the response arrives; that response is then suppressed.
  - Once latched, the transaction still completes downstream; only upstream signalling is suppressed.
  - Upstream guarantees that no kill ever targets a store that is already latched.
- Non-owner response: always '0. A non-owner requester holding valid simply waits.
- Back-to-back: at least 1 IDLE cycle between transactions. Minimum occupancy is 3 cycles for a 1-cycle addr_ok/data_ok slave.
- s_req fields other than valid are stable from ADDR entry until addr_ok (downstream protocol).

Optional Feature:
- Macro: DBUS_ARB_FIXED_PRIO_EN.
- Defined: m0 always wins over m1 (program order); last is unused and m1 can starve.
- Undefined: round-robin as above.

Decomposition:
- Shared package (common.svh): dbus_req_t, dbus_resp_t (existing); new arb_state_t enum {IDLE, ADDR, DATA}.
- Add the macro to the config header.
- No sub-module; grant selection is a local always_comb.

Test Plan:
- Single read: m0_req valid, addr=0x8000_0010, size=MSIZE4; slave gives addr_ok at t+2 and data_ok at t+3 with data 0xDEADBEEF.
  - Required: m0_resp.data_ok=1 with data 0xDEADBEEF at t+3; m1_resp stays '0.
- Simultaneous requests after reset: m0 addr 0x100, m1 addr 0x200.
  - Required: 0x100 is served first, then 0x200.
  - Then both valid again: the 0x200 requester (m1) is not preferred; the order alternates m0, m1, m0.
  - With DBUS_ARB_FIXED_PRIO_EN: m0 is always first.
- Store while m1 waits: m0 store strobe 4'b1100, data 0x12340000.
  - Required: s_req carries exactly that strobe and data and stays stable until addr_ok; m1 is granted only after m0's data_ok plus one IDLE cycle.
- Kill in DATA: m1 load in DATA, kill1=1 one cycle before data_ok.
  - Required: m1_resp.data_ok stays 0, the arbiter returns to IDLE, and the next grant proceeds normally.
- Kill in IDLE: kill0=1 with m0 valid.
  - Required: m0 is not granted and s_req.valid stays 0; a simultaneously valid m1 is granted.
- Reset during ADDR (slave withholding addr_ok).
  - Required: next cycle state=IDLE, s_req.valid=0, busy=0, and all responses are 0.
